l1_param_plru_cache: RTL and testbench

L1_PARAM_PLRU_CACHE -- requirements
Module: l1_param_plru_cache

---
 rtl/l1_param_plru_cache.sv | 111 +++++++++++
 tb/tb_l1_param_plru_cache.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/l1_param_plru_cache.sv
// l1_param_plru_cache: write-back set-associative L1 with tree-PLRU replacement and a single-line memory port.
module l1_param_plru_cache #(
  parameter int WAYS = 4,
  parameter int SETS = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [3:0]   mem_byte_enable_cpu,
  input  logic [31:0]  mem_address,
  input  logic [31:0]  mem_wdata_cpu,
  output logic         mem_resp,
  output logic [31:0]  mem_rdata_cpu,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [31:0]  pmem_address,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
);
  localparam int IW = $clog2(SETS);
  localparam int TW = 27 - IW;
  localparam int LW = $clog2(WAYS);
  localparam int WW = LW > 0 ? LW : 1;
  localparam int PW = WAYS > 1 ? WAYS - 1 : 1;
  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;
  state_t state, state_n;
  logic [255:0] data [SETS][WAYS];
  logic [TW-1:0] tags [SETS][WAYS];
  logic [WAYS-1:0] valid [SETS];
  logic [WAYS-1:0] dirty [SETS];
  logic [PW-1:0] plru [SETS];
  logic [WW-1:0] victim, vict_c, hit_way, plru_way;
  logic [PW-1:0] plru_next;
  logic [IW-1:0] idx;
  logic [TW-1:0] req_tag;
  logic [2:0] word;
  logic [1:0] unused_lsb;
  logic hit, req, fill_done;
  int n, p;
  assign idx = mem_address[5 +: IW];
  assign req_tag = mem_address[31 -: TW];
  assign word = mem_address[4:2];
  assign unused_lsb = mem_address[1:0];
  assign req = mem_read | mem_write;
  assign fill_done = state == FILL && pmem_resp;
  // Heap-ordered tree: node k lives at bit k-1; a 1 sends the victim search right.
  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    plru_way = '0;
    plru_next = plru[idx];
    n = 1;
    p = 0;
    for (int w = 0; w < WAYS; w++)
      if (valid[idx][w] && tags[idx][w] == req_tag) begin
        hit = 1'b1;
        hit_way = WW'(w);
      end
    if (WAYS > 1) begin
      for (int l = 0; l < LW; l++) n = 2 * n + int'(plru[idx][n-1]);
      plru_way = WW'(n - WAYS);
      p = WAYS + int'(hit_way);
      for (int l = 0; l < LW; l++) plru_next[(p >> (LW - l)) - 1] = ~p[LW-l-1];
    end
    vict_c = plru_way;
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid[idx][w]) vict_c = WW'(w);
  end
  always_comb begin
    state_n = state == IDLE ? ((req && !hit) ? ((valid[idx][vict_c] && dirty[idx][vict_c]) ? WRITEBACK : FILL) : IDLE)
            : pmem_resp ? (state == WRITEBACK ? FILL : IDLE) : state;
    mem_resp = state == IDLE && req && hit;
    mem_rdata_cpu = data[idx][hit_way][{word, 5'b0} +: 32];
    pmem_read = state == FILL;
    pmem_write = state == WRITEBACK;
    pmem_address = {state == WRITEBACK ? tags[idx][victim] : req_tag, idx, 5'b0};
    pmem_wdata = data[idx][victim];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      victim <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        dirty[s] <= '0;
        plru[s] <= '0;
      end
    end else begin
      state <= state_n;
      if (state == IDLE && req && !hit) victim <= vict_c;
      if (mem_resp) begin
        plru[idx] <= plru_next;
        if (mem_write) dirty[idx][hit_way] <= 1'b1;
      end
      if (fill_done) begin
        valid[idx][victim] <= 1'b1;
        dirty[idx][victim] <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (fill_done) begin
      data[idx][victim] <= pmem_rdata;
      tags[idx][victim] <= req_tag;
    end else if (mem_resp && mem_write)
      for (int b = 0; b < 4; b++)
        if (mem_byte_enable_cpu[b]) data[idx][hit_way][{word, 5'b0} + 8 * b +: 8] <= mem_wdata_cpu[8 * b +: 8];
  end
endmodule

// File: tb/tb_l1_param_plru_cache.sv
// tb_l1_param_plru_cache: scoreboard bench with a behavioural backing memory for the PLRU L1 cache.
module tb_l1_param_plru_cache;
  logic clk = 0, rst = 1, mem_read = 0, mem_write = 0, mem_resp, pmem_read, pmem_write, pmem_resp = 0;
  logic [3:0] mem_byte_enable_cpu = 0;
  logic [31:0] mem_address = 0, mem_wdata_cpu = 0, mem_rdata_cpu, pmem_address;
  logic [255:0] pmem_wdata, pmem_rdata = 0;
  typedef struct {logic wr; logic [31:0] data;} exp_t;
  exp_t sb[$];
  exp_t e;
  logic [255:0] mem [int unsigned];
  logic [255:0] view [int unsigned];
  int checks = 0, errors = 0, n_rd, n_wb, cyc, rd_cyc, wb_cyc;
  logic [31:0] fill_addr, wb_addr, last_rdata;
  logic [255:0] wb_data;
  logic both_seen = 0;
  l1_param_plru_cache #(.WAYS(4), .SETS(16)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable_cpu(mem_byte_enable_cpu), .mem_address(mem_address),
    .mem_wdata_cpu(mem_wdata_cpu), .mem_resp(mem_resp), .mem_rdata_cpu(mem_rdata_cpu),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );
  always #5 clk = ~clk;
  function automatic logic [255:0] base_line(input logic [31:0] a);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = (a + 32'(4 * k)) ^ 32'h5A00_0000;
    if (a == 32'h100) l[63:32] = 32'hDEADBEEF;
    return l;
  endfunction
  function automatic logic [255:0] mem_line(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : base_line(a);
  endfunction
  function automatic logic [255:0] view_line(input logic [31:0] a);
    return view.exists(a) ? view[a] : mem_line(a);
  endfunction
  always @(negedge clk)
    if (!rst) begin
      if (pmem_read && pmem_write) both_seen = 1;
      if (mem_resp) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_resp addr=%h", mem_address);
        end else begin
          e = sb.pop_front();
          if (!e.wr && mem_rdata_cpu !== e.data) begin
            errors++;
            $display("FAIL sb_rdata addr=%h got=%h exp=%h", mem_address, mem_rdata_cpu, e.data);
          end
        end
      end
    end
  task automatic req(input logic wr, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    logic [31:0] la;
    logic [255:0] l;
    bit done;
    la = {a[31:5], 5'b0};
    l = view_line(la);
    if (wr) begin
      for (int b = 0; b < 4; b++) if (be[b]) l[{a[4:2], 5'b0} + 8 * b +: 8] = wd[8*b +: 8];
      view[la] = l;
      sb.push_back('{1'b1, 32'h0});
    end else sb.push_back('{1'b0, l[{a[4:2], 5'b0} +: 32]});
    n_rd = 0; n_wb = 0; cyc = 0; done = 0;
    @(posedge clk); #1;
    mem_read = !wr; mem_write = wr; mem_address = a; mem_byte_enable_cpu = be; mem_wdata_cpu = wd;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (mem_resp) begin
        done = 1;
        last_rdata = mem_rdata_cpu;
      end else if (pmem_write) begin
        n_wb++; wb_cyc = cyc; wb_addr = pmem_address; wb_data = pmem_wdata;
        mem[pmem_address] = pmem_wdata;
        pmem_resp = 1;
      end else if (pmem_read) begin
        n_rd++; rd_cyc = cyc; fill_addr = pmem_address;
        pmem_rdata = mem_line(pmem_address);
        pmem_resp = 1;
      end
      @(posedge clk); #1;
      pmem_resp = 0;
    end
    mem_read = 0; mem_write = 0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL timeout addr=%h got=no_resp exp=resp", a);
      sb.delete();
    end
  endtask
  task automatic do_reset();
    rst = 1; mem_read = 0; mem_write = 0; pmem_resp = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    view.delete();
    sb.delete();
  endtask
  task automatic test_reset();
    rst = 1;
    #2;
    checks += 3;
    if (mem_resp !== 0) begin errors++; $display("FAIL reset_mem_resp got=%b exp=0", mem_resp); end
    if (pmem_read !== 0) begin errors++; $display("FAIL reset_pmem_read got=%b exp=0", pmem_read); end
    if (pmem_write !== 0) begin errors++; $display("FAIL reset_pmem_write got=%b exp=0", pmem_write); end
    do_reset();
  endtask
  task automatic test_read_miss();
    req(0, 32'h104, 4'h0, 0);
    checks += 4;
    if (n_rd !== 1) begin errors++; $display("FAIL miss_fill_count got=%0d exp=1", n_rd); end
    if (fill_addr !== 32'h100) begin errors++; $display("FAIL miss_fill_addr got=%h exp=00000100", fill_addr); end
    if (n_wb !== 0) begin errors++; $display("FAIL miss_wb_count got=%0d exp=0", n_wb); end
    if (last_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL miss_rdata got=%h exp=deadbeef", last_rdata); end
    req(0, 32'h104, 4'h0, 0);
    checks += 2;
    if (cyc !== 1) begin errors++; $display("FAIL hit_latency got=%0d exp=1", cyc); end
    if (n_rd + n_wb !== 0) begin errors++; $display("FAIL hit_pmem got=%0d exp=0", n_rd + n_wb); end
  endtask
  task automatic test_write_hit();
    req(1, 32'h104, 4'b0011, 32'h12345678);
    checks++;
    if (cyc !== 1 || n_rd !== 0) begin errors++; $display("FAIL write_hit got=cyc%0d/rd%0d exp=cyc1/rd0", cyc, n_rd); end
    req(0, 32'h104, 4'h0, 0);
    checks++;
    if (last_rdata !== 32'hDEAD5678) begin errors++; $display("FAIL write_merge got=%h exp=dead5678", last_rdata); end
  endtask
  task automatic test_writeback();
    logic [255:0] exp_line;
    exp_line = base_line(32'h100);
    exp_line[47:32] = 16'h5678;
    do_reset();
    req(0, 32'h100, 4'h0, 0);
    req(1, 32'h104, 4'b0011, 32'h12345678);
    req(0, 32'h300, 4'h0, 0);
    req(0, 32'h500, 4'h0, 0);
    req(0, 32'h700, 4'h0, 0);
    checks++;
    if (n_wb !== 0) begin errors++; $display("FAIL fill_set_wb got=%0d exp=0", n_wb); end
    req(0, 32'h900, 4'h0, 0);
    checks += 6;
    if (n_wb !== 1) begin errors++; $display("FAIL wb_count got=%0d exp=1", n_wb); end
    if (wb_addr !== 32'h100) begin errors++; $display("FAIL wb_addr got=%h exp=00000100", wb_addr); end
    if (wb_data !== exp_line) begin errors++; $display("FAIL wb_data got=%h exp=%h", wb_data, exp_line); end
    if (n_rd !== 1) begin errors++; $display("FAIL wb_fill_count got=%0d exp=1", n_rd); end
    if (fill_addr !== 32'h900) begin errors++; $display("FAIL wb_fill_addr got=%h exp=00000900", fill_addr); end
    if (!(wb_cyc < rd_cyc)) begin errors++; $display("FAIL wb_order got=wb%0d/rd%0d exp=wb_first", wb_cyc, rd_cyc); end
  endtask
  task automatic test_plru();
    logic [31:0] hits [3];
    hits = '{32'h100, 32'h300, 32'h700};
    do_reset();
    req(0, 32'h100, 4'h0, 0);
    req(0, 32'h300, 4'h0, 0);
    req(0, 32'h500, 4'h0, 0);
    req(0, 32'h700, 4'h0, 0);
    req(0, 32'h100, 4'h0, 0);
    checks++;
    if (cyc !== 1) begin errors++; $display("FAIL plru_rehit got=%0d exp=1", cyc); end
    req(0, 32'h900, 4'h0, 0);
    checks += 2;
    if (n_wb !== 0) begin errors++; $display("FAIL plru_clean_wb got=%0d exp=0", n_wb); end
    if (n_rd !== 1 || fill_addr !== 32'h900) begin errors++; $display("FAIL plru_fill got=%0d@%h exp=1@00000900", n_rd, fill_addr); end
    for (int i = 0; i < 3; i++) begin
      req(0, hits[i], 4'h0, 0);
      checks++;
      if (cyc !== 1) begin errors++; $display("FAIL plru_survivor %h got=%0d exp=1", hits[i], cyc); end
    end
    req(0, 32'h500, 4'h0, 0);
    checks++;
    if (n_rd !== 1) begin errors++; $display("FAIL plru_victim_500 got=%0d exp=1", n_rd); end
  endtask
  task automatic test_reset_mid_fill();
    do_reset();
    @(posedge clk); #1;
    mem_read = 1; mem_address = 32'h104;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (pmem_read !== 1) begin errors++; $display("FAIL midfill_pre got=%b exp=1", pmem_read); end
    #1 rst = 1;
    #1;
    checks += 2;
    if (pmem_read !== 0 || pmem_write !== 0) begin errors++; $display("FAIL midfill_pmem got=%b%b exp=00", pmem_read, pmem_write); end
    if (mem_resp !== 0) begin errors++; $display("FAIL midfill_resp got=%b exp=0", mem_resp); end
    mem_read = 0;
    do_reset();
    req(0, 32'h104, 4'h0, 0);
    checks++;
    if (n_rd !== 1 || fill_addr !== 32'h100) begin errors++; $display("FAIL midfill_reissue got=%0d@%h exp=1@00000100", n_rd, fill_addr); end
  endtask
  task automatic test_back_to_back();
    logic [31:0] a;
    do_reset();
    for (int i = 0; i < 80; i++) begin
      a = (32'($urandom_range(0, 5)) << 9) | (32'($urandom_range(0, 1)) << 5) | (32'($urandom_range(0, 7)) << 2);
      req(1'($urandom_range(0, 1)), a, 4'($urandom_range(1, 15)), $urandom);
    end
    checks += 2;
    if (both_seen !== 0) begin errors++; $display("FAIL pmem_exclusive got=%b exp=0", both_seen); end
    if (sb.size() !== 0) begin errors++; $display("FAIL sb_leftover got=%0d exp=0", sb.size()); end
  endtask
  initial begin
    test_reset();
    test_read_miss();
    test_write_hit();
    test_writeback();
    test_plru();
    test_reset_mid_fill();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
